// File: rtl/axis_cic_interp.sv
// CIC interpolator: signed WIDTH-bit low-rate samples in, RATE beats per sample
// out at unity DC gain. Comb stages run at the input rate, the integrators run
// at the output rate with zero-stuffing between them. Both AXI-Stream sides
// support full backpressure.
// Optional build macro AXIS_CIC_ROUND_EN: round half up before the gain-removal
// shift and saturate at the positive full-scale code. Undefined: truncate.
module axis_cic_interp #(
  parameter int WIDTH = 16,
  parameter int RATE  = 8,
  parameter int ORDER = 3
) (
  input  logic                    aclk,
  input  logic                    arst_n,
  input  logic signed [WIDTH-1:0] s_axis_data_tdata,
  input  logic                    s_axis_data_tvalid,
  output logic                    s_axis_data_tready,
  output logic signed [WIDTH-1:0] m_axis_data_tdata,
  output logic                    m_axis_data_tvalid,
  input  logic                    m_axis_data_tready
);

  localparam int LOG2R = $clog2(RATE);
  // Gain of the filter is RATE^(ORDER-1); removing it is a shift by S bits.
  localparam int S     = (ORDER - 1) * LOG2R;
  localparam int IW    = WIDTH + S;
  localparam int CW    = $clog2(RATE + 1);

  logic signed [IW-1:0] comb_dly_q [ORDER];
  logic signed [IW-1:0] integ_q    [ORDER];
  logic signed [IW-1:0] comb_q;
  logic signed [IW-1:0] comb_w     [ORDER+1];
  logic signed [IW-1:0] last_integ;
  logic [CW-1:0]        cnt_q;
  logic                 first_q;
  logic                 m_tvalid_q;
  logic                 step_en;
  logic                 accept;

  // A step needs work left for this sample and a free output register.
  assign step_en = (cnt_q != '0) && (!m_tvalid_q || m_axis_data_tready);

  // A new sample may land on the very edge that performs the last step.
  assign s_axis_data_tready = arst_n &&
                              ((cnt_q == '0) || ((cnt_q == CW'(1)) && step_en));
  assign accept             = s_axis_data_tvalid && s_axis_data_tready;
  assign m_axis_data_tvalid = m_tvalid_q;
  assign last_integ         = integ_q[ORDER-1];

  // Comb cascade on the incoming sample; y = x - x_delayed per stage.
  always_comb begin
    // NOTE: every element is assigned on every pass, so no latch is inferred.
    comb_w[0] = IW'(s_axis_data_tdata);
    for (int k = 0; k < ORDER; k++) begin
      comb_w[k+1] = comb_w[k] - comb_dly_q[k];
    end
  end

  // Comb capture on accept, integrator cascade on each step, beat handshake.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      // NOTE: these small arrays are filter state, so they are reset like any
      // other register; a burst cut by reset must not leak into the next one.
      for (int k = 0; k < ORDER; k++) begin
        comb_dly_q[k] <= '0;
        integ_q[k]    <= '0;
      end
      comb_q     <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < ORDER; k++) begin
          comb_dly_q[k] <= comb_w[k];
        end
        comb_q <= comb_w[ORDER];
      end

      if (step_en) begin
        // NOTE: non-blocking updates make every stage add its predecessor's
        // pre-update value, which is the one-edge-per-stage pipeline we want.
        integ_q[0] <= integ_q[0] + (first_q ? comb_q : '0);
        for (int k = 1; k < ORDER; k++) begin
          integ_q[k] <= integ_q[k] + integ_q[k-1];
        end
        first_q    <= 1'b0;
        m_tvalid_q <= 1'b1;
      end else if (m_axis_data_tready) begin
        m_tvalid_q <= 1'b0;
      end

      // Accept wins over the step's decrement and first-flag clear.
      if (accept) begin
        cnt_q   <= CW'(RATE);
        first_q <= 1'b1;
      end else if (step_en) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

`ifdef AXIS_CIC_ROUND_EN
  generate
    if (S == 0) begin : g_plain
      assign m_axis_data_tdata = WIDTH'(last_integ);
    end else begin : g_round
      localparam logic signed [IW:0] HALF = (IW+1)'(1) <<< (S - 1);
      logic signed [IW:0]    rnd;
      logic signed [WIDTH:0] rnd_sh;
      // One extra bit keeps the half-LSB addition from wrapping.
      assign rnd    = {last_integ[IW-1], last_integ} + HALF;
      assign rnd_sh = (WIDTH+1)'(rnd >>> S);
      assign m_axis_data_tdata = (!rnd_sh[WIDTH] && rnd_sh[WIDTH-1])
                                 ? {1'b0, {(WIDTH-1){1'b1}}}
                                 : rnd_sh[WIDTH-1:0];
    end
  endgenerate
`else
  // Truncating arithmetic shift: a plain slice of the last integrator.
  assign m_axis_data_tdata = WIDTH'(last_integ >>> S);
`endif

endmodule
